uart_rx_oversampled: RTL and testbench

Standalone UART receiver. It recovers 8N1 frames from a serial RX line using a clock-cycle baud counter. Each completed byte is delivered through a Valid/Ready holding register. It is the receive end that pairs with the team's UART transmit path, and it sits between the RX pad and the byte consumer.

---
 rtl/uart_rx_oversampled.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_oversampled
//  Purpose  : UART receiver with a clock-count baud timer. It recovers
//             start + DATA_BITS (LSB first) + stop frames from RX and hands
//             each byte to the consumer through a Valid/Ready holding register.
//  Option   : define UART_RX_PARITY_EN to add an even-parity bit after the
//             data bits and drive ParityErr; otherwise ParityErr is tied 0.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 CLK,
   input  logic                 Reset_n,
   input  logic                 EN,
   input  logic                 RX,
   output logic [DATA_BITS-1:0] DataOUT,
   output logic                 Valid,
   input  logic                 Ready,
   output logic                 FrameErr,
   output logic                 Overrun,
   output logic                 ParityErr
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd4;
   localparam logic [2:0] WAIT_IDLE = 3'd5;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY    = 3'd3;
`endif

   logic                 rx_meta;
   logic                 rx_s;
   logic [2:0]           state;
   logic [2:0]           next_state;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 tick;
   logic                 byte_done;
   logic                 stop_err;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_s    <= rx_meta;
      end
   end

   // Baud tick: half a bit to reach mid-start, a full bit for every later sample.
   always_comb begin
      tick = 1'b0;
      case (state)
         START:     tick = (baud_cnt == BAUD_HALF);
         DATA,
`ifdef UART_RX_PARITY_EN
         PARITY,
`endif
         STOP:      tick = (baud_cnt == BAUD_FULL);
         default:   tick = 1'b0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // FSM next-state logic; a low EN overrides everything and parks in IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (!rx_s) next_state = START;
         START:     if (tick) next_state = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:      if (tick && bit_cnt == BIT_LAST) next_state = PARITY;
         PARITY:    if (tick) next_state = STOP;
`else
         DATA:      if (tick && bit_cnt == BIT_LAST) next_state = STOP;
`endif
         STOP:      if (tick) next_state = rx_s ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rx_s) next_state = IDLE;
         default:   next_state = IDLE;
      endcase
      if (!EN) next_state = IDLE;
   end

   // FSM outputs: completion and framing-error strobes at the stop sample.
   always_comb begin
      byte_done = 1'b0;
      stop_err  = 1'b0;
      if (EN && state == STOP && tick) begin
         byte_done = rx_s;
         stop_err  = !rx_s;
      end
   end

   // Baud counter, bit counter and the LSB-first data shift register.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         if (!EN || state == IDLE || state == WAIT_IDLE || tick)
            baud_cnt <= '0;
         else
            baud_cnt <= baud_cnt + 1'b1;

         if (EN && state == DATA) begin
            if (tick) bit_cnt <= bit_cnt + 1'b1;
         end else begin
            bit_cnt <= '0;
         end

         if (EN && state == DATA && tick)
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      end
   end

   // Holding register and error pulses; a full buffer without Ready drops the new byte.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         DataOUT  <= '0;
         Valid    <= 1'b0;
         FrameErr <= 1'b0;
         Overrun  <= 1'b0;
      end else begin
         FrameErr <= stop_err;
         Overrun  <= byte_done && Valid && !Ready;
         if (byte_done && (!Valid || Ready)) begin
            DataOUT <= shift_reg;
            Valid   <= 1'b1;
         end else if (Valid && Ready) begin
            Valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic parity_bit;

   // Capture the parity bit, then flag an odd total at the stop sample.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         parity_bit <= 1'b0;
         ParityErr  <= 1'b0;
      end else begin
         if (EN && state == PARITY && tick) parity_bit <= rx_s;
         ParityErr <= EN && state == STOP && tick && (^{shift_reg, parity_bit});
      end
   end
`else
   assign ParityErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_oversampled
//  Purpose  : Self-checking bench for uart_rx_oversampled (CLKS_PER_BIT=4).
//             Expected bytes are queued as frames are sent and compared when
//             the consumer handshake takes them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;

   localparam int C = 4;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       en    = 1'b1;
   logic       rx    = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data_out;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int fe_cycles   = 0;
   int ov_cycles   = 0;
   int pe_cycles   = 0;
   logic [7:0] exp_q[$];

   uart_rx_oversampled #(
      .CLKS_PER_BIT(C),
      .DATA_BITS   (8)
   ) dut (
      .CLK      (clk),
      .Reset_n  (rst_n),
      .EN       (en),
      .RX       (rx),
      .DataOUT  (data_out),
      .Valid    (valid),
      .Ready    (ready),
      .FrameErr (frame_err),
      .Overrun  (overrun),
      .ParityErr(parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      idle(C);
   endtask

   // Full frame; the even-parity bit is inverted when par_flip is set.
   task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      if (PAR == 1) drive_bit((^b) ^ par_flip);
      drive_bit(stop_bit);
   endtask

   // Scoreboard side: count error-pulse cycles and check every consumed byte.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err)  fe_cycles++;
         if (overrun)    ov_cycles++;
         if (parity_err) pe_cycles++;
         if (valid && ready) begin
            check("byte_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("byte_data", {24'b0, data_out}, {24'b0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      int fe0;
      int ov0;
      logic [7:0] b;

      // Reset state
      idle(2);
      check("rst_data",   {24'b0, data_out}, 32'h0);
      check("rst_valid",  {31'b0, valid},      32'd0);
      check("rst_ferr",   {31'b0, frame_err},  32'd0);
      check("rst_ovr",    {31'b0, overrun},    32'd0);
      check("rst_perr",   {31'b0, parity_err}, 32'd0);
      rst_n = 1'b1;
      idle(3);

      // 1: single byte, latency from the first edge that sees RX low
      exp_q.push_back(8'hEA);
      k = cyc;
      send(8'hEA, 1'b1, 1'b0);
      for (int i = 0; i < 20 && !valid; i++) idle(1);
      check("t1_latency", cyc, k + 41 + PAR * C);
      check("t1_data", {24'b0, data_out}, 32'hEA);
      idle(1);
      check("t1_valid_1cyc", {31'b0, valid}, 32'd0);

      // 2: one-cycle glitch is ignored
      fe0 = fe_cycles;
      rx = 1'b0;
      idle(1);
      rx = 1'b1;
      idle(20);
      check("t2_valid", {31'b0, valid}, 32'd0);
      check("t2_ferr", fe_cycles, fe0);

      // 3: bad stop bit followed by a break, then a good frame
      send(8'h3C, 1'b0, 1'b0);
      idle(1);
      check("t3_ferr_pulse", {31'b0, frame_err}, 32'd1);
      check("t3_valid", {31'b0, valid}, 32'd0);
      idle(3 * C);
      check("t3_ferr_once", fe_cycles, fe0 + 1);
      check("t3_no_frame", {31'b0, valid}, 32'd0);
      rx = 1'b1;
      idle(4);
      exp_q.push_back(8'h81);
      send(8'h81, 1'b1, 1'b0);
      idle(3);
      check("t3_ferr_total", fe_cycles, fe0 + 1);
      check("t3_q_empty", exp_q.size(), 0);

      // 4: overrun while the consumer stalls
      ready = 1'b0;
      ov0 = ov_cycles;
      exp_q.push_back(8'h55);
      send(8'h55, 1'b1, 1'b0);
      send(8'hA3, 1'b1, 1'b0);
      idle(1);
      check("t4_ovr_pulse", {31'b0, overrun}, 32'd1);
      check("t4_data_held", {24'b0, data_out}, 32'h55);
      check("t4_valid", {31'b0, valid}, 32'd1);
      idle(1);
      check("t4_ovr_width", ov_cycles, ov0 + 1);
      ready = 1'b1;
      idle(1);
      check("t4_valid_clr", {31'b0, valid}, 32'd0);
      ready = 1'b0;

      // 5: Ready on the exact completion edge replaces the pending byte
      exp_q.push_back(8'h34);
      send(8'h34, 1'b1, 1'b0);
      idle(4);
      exp_q.push_back(8'h12);
      send(8'h12, 1'b1, 1'b0);
      ready = 1'b1;
      idle(1);
      ready = 1'b0;
      check("t5_data", {24'b0, data_out}, 32'h12);
      check("t5_valid", {31'b0, valid}, 32'd1);
      check("t5_no_ovr", {31'b0, overrun}, 32'd0);
      idle(1);
      check("t5_ovr_count", ov_cycles, ov0 + 1);
      ready = 1'b1;
      idle(1);
      check("t5_valid_clr", {31'b0, valid}, 32'd0);

      // 6: asynchronous reset during data bit 4 of 0xF0
      b = 8'hF0;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b[i]);
      rx = b[4];
      idle(3);
      rst_n = 1'b0;
      #1;
      check("t6_rst_data", {24'b0, data_out}, 32'h0);
      check("t6_rst_valid", {31'b0, valid}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(10);
      check("t6_no_f0", {31'b0, valid}, 32'd0);
      exp_q.push_back(8'h0F);
      send(8'h0F, 1'b1, 1'b0);
      idle(3);
      check("t6_q_empty", exp_q.size(), 0);

      // EN dropped mid-frame: no delivery, no errors, then normal reception
      fe0 = fe_cycles;
      ov0 = ov_cycles;
      b = 8'h99;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 2) en = 1'b0;
         drive_bit(b[i]);
      end
      if (PAR == 1) drive_bit(^b);
      drive_bit(1'b1);
      idle(5);
      en = 1'b1;
      idle(5);
      check("en_no_valid", {31'b0, valid}, 32'd0);
      check("en_no_ferr", fe_cycles, fe0);
      check("en_no_ovr", ov_cycles, ov0);
      exp_q.push_back(8'hC3);
      send(8'hC3, 1'b1, 1'b0);
      idle(3);

`ifdef UART_RX_PARITY_EN
      // Parity error: 0x07 with parity bit 0 is still delivered
      exp_q.push_back(8'h07);
      send(8'h07, 1'b1, 1'b1);
      idle(1);
      check("par_pulse", {31'b0, parity_err}, 32'd1);
      check("par_data", {24'b0, data_out}, 32'h07);
      idle(2);
      check("par_total", pe_cycles, 1);
`else
      check("par_tied0", pe_cycles, 0);
`endif

      check("end_q_empty", exp_q.size(), 0);
      check("end_ferr_total", fe_cycles, 1);
      check("end_ovr_total", ov_cycles, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
